regfile_wb_sched: RTL and testbench

Write-back scheduler for the 32x32 register bank in the MIPS32 5-stage pipeline. It shares the single regbank write port among NREQ write-back requesters (ALU, load, mul/div) using round-robin arbitration, and drives a registered write command into the bank. It also keeps a per-register pending scoreboard. Decode/issue uses the scoreboard for RAW stall detection and WAW-safe allocation.

---
 rtl/regfile_wb_sched_pkg.sv | 15 +
 rtl/regfile_wb_sched_if.sv | 30 +++
 rtl/regfile_wb_sched_rr_arbiter.sv | 53 +++++
 rtl/regfile_wb_sched.sv | 107 ++++++++++
 tb/tb_regfile_wb_sched.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_sched_pkg.sv
// Shared constants for the register-bank write-back scheduler: default widths,
// requester slot indices and the hard-wired zero register.
package regfile_wb_sched_pkg;

    localparam int DEF_NREQ = 3;
    localparam int DEF_DW   = 32;
    localparam int DEF_AW   = 5;

    localparam int REQ_ALU  = 0;
    localparam int REQ_LD   = 1;
    localparam int REQ_MD   = 2;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_wb_sched_if.sv
// Write-back request bus between the pipeline's producers (ALU, load, mul/div)
// and the scheduler. Slice i of req_dr/req_data belongs to requester i.
interface regfile_wb_sched_if
    import regfile_wb_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW
) ();

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_dr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;

    modport master (
        output req_valid,
        output req_dr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_dr,
        input  req_data,
        output req_ready
    );

endinterface

// File: rtl/regfile_wb_sched_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer, and after an accepted
// grant the pointer moves to the slot just after the winner.
module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gnt_idx;
    logic [PW-1:0] idx;
    logic [PW:0]   sum;
    logic          found;

    // NOTE: every combinational output gets a default before the loop; a path
    // that leaves a variable unassigned would infer a latch.
    always_comb begin
        grant   = '0;
        gnt_idx = ptr;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (PW+1)'(k);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                gnt_idx    = idx;
                found      = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler: round-robin access to the single regbank write port,
// plus a per-register pending scoreboard for RAW stalls and WAW-safe allocation.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW
) (
    input  logic                clk,
    input  logic                reset_n,
    regfile_wb_sched_if.slave   bus,
    output logic                rf_write,
    output logic [AW-1:0]       rf_dr,
    output logic [DW-1:0]       rf_wrData,
    input  logic                alloc_valid,
    input  logic [AW-1:0]       alloc_dr,
    output logic                alloc_ready,
    input  logic [AW-1:0]       sr1,
    input  logic [AW-1:0]       sr2,
    output logic                sr1_busy,
    output logic                sr2_busy,
    output logic                stall,
    input  logic                flush
);

    localparam int NREG = 1 << AW;

    logic [NREQ-1:0] grant;
    logic            transfer;
    logic [AW-1:0]   sel_dr;
    logic [DW-1:0]   sel_data;
    logic [NREG-1:0] pend;
    logic [NREG-1:0] pend_nxt;
    logic            alloc_set;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .advance (transfer),
        .grant   (grant)
    );

    assign bus.req_ready = grant;
    assign transfer      = |(bus.req_valid & grant);

    always_comb begin
        sel_dr   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_dr   = bus.req_dr[i*AW +: AW];
                sel_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    // Writes to $zero are accepted on the bus but never reach the bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_write  <= 1'b0;
            rf_dr     <= '0;
            rf_wrData <= '0;
        end else if (transfer) begin
            rf_write  <= (sel_dr != AW'(REG_ZERO));
            rf_dr     <= sel_dr;
            rf_wrData <= sel_data;
        end else begin
            rf_write  <= 1'b0;
        end
    end

    // A claim on a pending register is still accepted in the producer's commit cycle.
    assign alloc_ready = !pend[alloc_dr] || (rf_write && (rf_dr == alloc_dr));
    assign alloc_set   = alloc_valid && alloc_ready && (alloc_dr != AW'(REG_ZERO));

    // Clear before set so a new producer keeps ownership; flush overrides both.
    always_comb begin
        pend_nxt = pend;
        if (rf_write) begin
            pend_nxt[rf_dr] = 1'b0;
        end
        if (alloc_set) begin
            pend_nxt[alloc_dr] = 1'b1;
        end
        if (flush) begin
            pend_nxt = '0;
        end
        pend_nxt[REG_ZERO] = 1'b0;
    end

    // NOTE: the scoreboard is only 32 flops of control state, so it takes the
    // async reset; a data array would normally be left unreset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

    assign sr1_busy = pend[sr1];
    assign sr2_busy = pend[sr2];
    assign stall    = sr1_busy || sr2_busy;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Randomised and directed bench for regfile_wb_sched: a behavioural model
// predicts grants and scoreboard state; a monitor checks the regbank commands.
module tb_regfile_wb_sched;
    import regfile_wb_sched_pkg::*;

    localparam int NREQ = DEF_NREQ;
    localparam int DW   = DEF_DW;
    localparam int AW   = DEF_AW;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          rf_write;
    logic [AW-1:0] rf_dr;
    logic [DW-1:0] rf_wrData;
    logic          alloc_valid;
    logic [AW-1:0] alloc_dr;
    logic          alloc_ready;
    logic [AW-1:0] sr1, sr2;
    logic          sr1_busy, sr2_busy, stall;
    logic          flush;

    regfile_wb_sched_if #(.NREQ(NREQ), .DW(DW), .AW(AW)) bus ();

    regfile_wb_sched #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .rf_write    (rf_write),
        .rf_dr       (rf_dr),
        .rf_wrData   (rf_wrData),
        .alloc_valid (alloc_valid),
        .alloc_dr    (alloc_dr),
        .alloc_ready (alloc_ready),
        .sr1         (sr1),
        .sr2         (sr2),
        .sr1_busy    (sr1_busy),
        .sr2_busy    (sr2_busy),
        .stall       (stall),
        .flush       (flush)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester state: a request stays up, unchanged, until it is granted.
    logic          rv[NREQ];
    logic [AW-1:0] rdr[NREQ];
    logic [DW-1:0] rdata[NREQ];

    // Reference model: rotating priority origin, pending set, and the write
    // that the bank will perform on the next edge.
    int            m_ptr;
    bit [31:0]     m_pend;
    bit            m_infl_v;
    logic [AW-1:0] m_infl_dr;
    int            cur_g;
    bit            exp_aready;

    typedef struct {
        logic [AW-1:0] dr;
        logic [DW-1:0] data;
    } wb_t;
    wb_t sb_q[$];
    wb_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        logic [NREQ-1:0]    v;
        logic [NREQ*AW-1:0] d;
        logic [NREQ*DW-1:0] w;
        for (int i = 0; i < NREQ; i++) begin
            v[i]          = rv[i];
            d[i*AW +: AW] = rdr[i];
            w[i*DW +: DW] = rdata[i];
        end
        bus.req_valid = v;
        bus.req_dr    = d;
        bus.req_data  = w;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < NREQ; k++) begin
            if (rv[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input int dr, input logic [DW-1:0] data);
        rv[i]    = 1'b1;
        rdr[i]   = AW'(dr);
        rdata[i] = data;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
    endtask

    task automatic model_reset();
        m_ptr    = 0;
        m_pend   = '0;
        m_infl_v = 1'b0;
        m_infl_dr = '0;
        clear_reqs();
        sb_q.delete();
    endtask

    // Drives inputs just after the falling edge and checks combinational outputs.
    task automatic comb_check();
        logic [NREQ-1:0] exp_rdy;
        drive();
        #1;
        cur_g   = model_grant();
        exp_rdy = (cur_g >= 0) ? (NREQ'(1) << cur_g) : '0;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        exp_aready = !m_pend[alloc_dr] || (m_infl_v && (m_infl_dr == alloc_dr));
        check("alloc_ready", 32'(alloc_ready), 32'(exp_aready));
        check("sr1_busy", 32'(sr1_busy), 32'(m_pend[sr1]));
        check("sr2_busy", 32'(sr2_busy), 32'(m_pend[sr2]));
        check("stall", 32'(stall), 32'(m_pend[sr1] | m_pend[sr2]));
    endtask

    task automatic model_edge();
        if (m_infl_v) m_pend[m_infl_dr] = 1'b0;
        if (alloc_valid && exp_aready && (alloc_dr != 0)) m_pend[alloc_dr] = 1'b1;
        if (flush) m_pend = '0;
        m_infl_v = 1'b0;
        if (cur_g >= 0) begin
            if (rdr[cur_g] != 0) begin
                sb_q.push_back('{dr: rdr[cur_g], data: rdata[cur_g]});
                m_infl_v  = 1'b1;
                m_infl_dr = rdr[cur_g];
            end
            m_ptr     = (cur_g + 1) % NREQ;
            rv[cur_g] = 1'b0;
        end
    endtask

    task automatic step();
        comb_check();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Monitor: each edge either delivers the oldest expected write or no write.
    always @(posedge clk) begin
        #1;
        if (reset_n) begin
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("rf_write", 32'(rf_write), 32'd1);
                check("rf_dr", 32'(rf_dr), 32'(mon_e.dr));
                check("rf_wrData", rf_wrData, mon_e.data);
            end else begin
                check("rf_write_idle", 32'(rf_write), 32'd0);
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        alloc_valid = 1'b0;
        alloc_dr    = '0;
        sr1         = '0;
        sr2         = '0;
        flush       = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rdr[i]   = '0;
            rdata[i] = '0;
        end
        model_reset();
        drive();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        check("reset_rf_write", 32'(rf_write), 32'd0);
        check("reset_rf_dr", 32'(rf_dr), 32'd0);
        check("reset_rf_wrData", rf_wrData, 32'd0);
        step();

        // All requesters continuously valid: rotation 001, 010, 100, 001.
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 10 + i, DW'(32'hA0 + i));
            step();
        end
        rv[REQ_LD] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            set_req(REQ_ALU, 10, 32'hA0);
            set_req(REQ_MD, 12, 32'hA2);
            step();
        end
        clear_reqs();
        step();

        // Single write-back to r5; sr1 stays busy through the commit edge.
        alloc_valid = 1'b1; alloc_dr = 5; step();
        alloc_valid = 1'b0;
        sr1 = 5;
        set_req(REQ_ALU, 5, 32'hDEADBEEF);
        step();
        step();
        step();

        // $zero: accepted, never written, never pending.
        set_req(REQ_MD, 0, 32'h1234);
        alloc_valid = 1'b1; alloc_dr = 0; sr1 = 0;
        step();
        alloc_valid = 1'b0;
        step();

        // WAW on r7, with set and clear of r7 colliding in the commit cycle.
        alloc_valid = 1'b1; alloc_dr = 7; sr2 = 7;
        step();
        step();
        set_req(REQ_LD, 7, 32'h0000_7777);
        step();
        step();
        alloc_valid = 1'b0;
        step();
        set_req(REQ_LD, 7, 32'h0000_7778);
        step();
        step();
        step();

        // Flush beats a simultaneous alloc.
        alloc_valid = 1'b1; alloc_dr = 3; step();
        alloc_dr = 9; step();
        flush = 1'b1; alloc_dr = 4; step();
        flush = 1'b0; alloc_valid = 1'b0;
        sr1 = 3; sr2 = 9; step();
        sr2 = 4; step();

        // Randomised traffic on a small register window to force collisions.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!rv[i] && ($urandom_range(0, 1) == 1)) begin
                    set_req(i, $urandom_range(0, 7), DW'($urandom()));
                end
            end
            alloc_valid = 1'($urandom_range(0, 1));
            alloc_dr    = AW'($urandom_range(0, 7));
            sr1         = AW'($urandom_range(0, 7));
            sr2         = AW'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;

        // Asynchronous reset while a write command is on the bank port.
        clear_reqs();
        set_req(REQ_LD, 9, 32'hCAFEF00D);
        alloc_valid = 1'b1; alloc_dr = 9; sr1 = 9;
        comb_check();
        @(posedge clk);
        model_edge();
        #2;
        check("pre_reset_rf_write", 32'(rf_write), 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_rf_write", 32'(rf_write), 32'd0);
        check("async_rf_dr", 32'(rf_dr), 32'd0);
        check("async_rf_wrData", rf_wrData, 32'd0);
        check("async_sr1_busy", 32'(sr1_busy), 32'd0);
        model_reset();
        alloc_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;

        // Pointer restarts at requester 0 after reset.
        for (int i = 0; i < NREQ; i++) set_req(i, 20 + i, DW'(32'hB0 + i));
        step();
        step();
        clear_reqs();
        repeat (3) step();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
